countdown_64_bit: RTL and testbench

Loadable 64-bit down-counter with terminal-count detection and an expiry handshake. It consumes the same load/wen/din control style as the 64-bit up-counter. It converts a loaded value into a timed event: it decrements to zero, then raises `expired` and holds it until the consumer acknowledges. It sits between a software-visible load register and a downstream event consumer (interrupt or sequencer).

---
 rtl/countdown_pkg.sv | 17 +
 rtl/countdown_64_bit_dp.sv | 77 +++++++
 rtl/countdown_64_bit_formal.sv | 104 ++++++++++
 rtl/countdown_64_bit.sv | 113 +++++++++++
 tb/tb_countdown_64_bit.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/countdown_pkg.sv
// Shared types and constants for the countdown_64_bit block.
//   countdown_state_t : FSM state encoding (IDLE, RUN, DONE)
//   COUNTDOWN_WIDTH   : default counter width
//   COUNTDOWN_ONE     : terminal-compare constant (count == 1)
package countdown_pkg;

    localparam int unsigned COUNTDOWN_WIDTH = 64;

    localparam logic [COUNTDOWN_WIDTH-1:0] COUNTDOWN_ONE = COUNTDOWN_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } countdown_state_t;

endpackage

// File: rtl/countdown_64_bit_dp.sv
// Datapath for countdown_64_bit: count register, optional reload register,
// decrement and terminal compare.
// Optional feature: COUNTDOWN_64_BIT_AUTO_RELOAD_EN (terminal decrement reloads).
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   i_load      : load i_din into count (and reload register)
//   i_din       : load value
//   i_dec       : apply one decrement step this cycle (already qualified by FSM)
//   o_count     : count register
//   o_term_c    : combinational strobe, count == 1
module countdown_64_bit_dp
    import countdown_pkg::*;
#(
    parameter int unsigned WIDTH = COUNTDOWN_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_dec,
    output logic [WIDTH-1:0] o_count,
    output logic             o_term_c
);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_nxt;
    logic             w_term;

`ifdef COUNTDOWN_64_BIT_AUTO_RELOAD_EN
    logic [WIDTH-1:0] r_reload;
`endif

    // Terminal compare: the next decrement reaches zero.
    assign w_term = (r_count == WIDTH'(COUNTDOWN_ONE));

    // Next count: load wins, then decrement; a terminal step never wraps.
    always_comb begin
        w_count_nxt = r_count;
        if (i_load) begin
            w_count_nxt = i_din;
        end else if (i_dec) begin
            if (w_term) begin
`ifdef COUNTDOWN_64_BIT_AUTO_RELOAD_EN
                w_count_nxt = r_reload;
`else
                w_count_nxt = '0;
`endif
            end else begin
                w_count_nxt = r_count - WIDTH'(1);
            end
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_nxt;
        end
    end

`ifdef COUNTDOWN_64_BIT_AUTO_RELOAD_EN
    // Reload register, captured on every load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_reload <= '0;
        end else if (i_load) begin
            r_reload <= i_din;
        end
    end
`endif

    assign o_count  = r_count;
    assign o_term_c = w_term;

endmodule

// File: rtl/countdown_64_bit_formal.sv
// Property checker for countdown_64_bit; observes the block's ports only.
// Optional feature: COUNTDOWN_64_BIT_AUTO_RELOAD_EN selects reload-mode rules.
// Ports: all inputs, mirroring the countdown_64_bit port list (outputs as i_*).
module countdown_64_bit_formal
    import countdown_pkg::*;
#(
    parameter int unsigned WIDTH = COUNTDOWN_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_wen,
    input  logic             i_ack,
    input  logic [WIDTH-1:0] i_count,
    input  logic             i_busy,
    input  logic             i_expired,
    input  logic             i_zero
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(COUNTDOWN_ONE);

    logic r_past_valid;

    // $past is meaningful only once one clocked cycle has passed out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_past_valid <= 1'b0;
        end else begin
            r_past_valid <= 1'b1;
        end
    end

`ifdef COUNTDOWN_64_BIT_AUTO_RELOAD_EN
    logic [WIDTH-1:0] r_shadow;

    // Independent copy of the last loaded value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow <= '0;
        end else if (i_load) begin
            r_shadow <= i_din;
        end
    end
`endif

    a_zero_decode: assert property (@(posedge clk) disable iff (!rst_n)
        i_zero == (i_count == '0));

    a_load: assert property (@(posedge clk) disable iff (!rst_n)
        r_past_valid && $past(i_load) |->
            (i_count == $past(i_din)) && !i_expired && (i_busy == ($past(i_din) != '0)));

    a_idle_hold: assert property (@(posedge clk) disable iff (!rst_n)
        r_past_valid && !$past(i_load) && !$past(i_busy) && !$past(i_expired) |->
            (i_count == '0) && !i_busy && !i_expired);

    a_run_dec: assert property (@(posedge clk) disable iff (!rst_n)
        r_past_valid && $past(i_busy) && !$past(i_load) && $past(i_wen) && ($past(i_count) > ONE) |->
            (i_count == $past(i_count) - ONE) && i_busy && !i_expired);

    a_run_hold: assert property (@(posedge clk) disable iff (!rst_n)
        r_past_valid && $past(i_busy) && !$past(i_load) && !$past(i_wen) |->
            (i_count == $past(i_count)) && i_busy && !i_expired);

`ifdef COUNTDOWN_64_BIT_AUTO_RELOAD_EN
    a_run_term: assert property (@(posedge clk) disable iff (!rst_n)
        r_past_valid && $past(i_busy) && !$past(i_load) && $past(i_wen) && ($past(i_count) == ONE) |->
            (i_count == r_shadow) && i_busy && i_expired);

    a_pulse: assert property (@(posedge clk) disable iff (!rst_n)
        r_past_valid && $past(i_expired) && !$past(i_load) &&
        !($past(i_wen) && ($past(i_count) == ONE)) |-> !i_expired);

    a_run_mono: assert property (@(posedge clk) disable iff (!rst_n)
        r_past_valid && $past(i_busy) && !$past(i_load) && ($past(i_count) != ONE) |->
            i_count <= $past(i_count));
`else
    a_run_term: assert property (@(posedge clk) disable iff (!rst_n)
        r_past_valid && $past(i_busy) && !$past(i_load) && $past(i_wen) && ($past(i_count) == ONE) |->
            (i_count == '0) && !i_busy && i_expired);

    a_done_hold: assert property (@(posedge clk) disable iff (!rst_n)
        r_past_valid && $past(i_expired) && !$past(i_load) && !$past(i_ack) |->
            i_expired && (i_count == '0) && !i_busy);

    a_done_ack: assert property (@(posedge clk) disable iff (!rst_n)
        r_past_valid && $past(i_expired) && !$past(i_load) && $past(i_ack) |->
            !i_expired && (i_count == '0) && !i_busy);

    a_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(i_busy && i_expired));

    a_run_mono: assert property (@(posedge clk) disable iff (!rst_n)
        r_past_valid && $past(i_busy) && !$past(i_load) |-> i_count <= $past(i_count));
`endif

    c_expire_after_3: cover property (@(posedge clk) disable iff (!rst_n)
        i_expired && $past(i_load, 4) && ($past(i_din, 4) == WIDTH'(3)));

    c_deadbeef: cover property (@(posedge clk) disable iff (!rst_n)
        i_count == WIDTH'(64'hDEADBEEFCAFEBABE));

endmodule

// File: rtl/countdown_64_bit.sv
// Loadable down-counter with terminal-count detection and expiry handshake.
// Optional feature: COUNTDOWN_64_BIT_AUTO_RELOAD_EN (reload on terminal count,
// expired becomes a one-cycle pulse, DONE unreachable).
// Ports:
//   clk, rst_n : clock, async active-low reset
//   i_load     : load i_din (highest priority)
//   i_din      : load value
//   i_wen      : decrement enable, acted on only in RUN
//   i_ack      : acknowledge of o_expired, acted on only in DONE
//   o_count    : counter value (registered)
//   o_busy     : state is RUN (registered)
//   o_expired  : terminal-count flag (registered)
//   o_zero     : o_count == 0, combinational decode of the count register
module countdown_64_bit
    import countdown_pkg::*;
#(
    parameter int unsigned WIDTH = COUNTDOWN_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_wen,
    input  logic             i_ack,
    output logic [WIDTH-1:0] o_count,
    output logic             o_busy,
    output logic             o_expired,
    output logic             o_zero
);

    countdown_state_t r_state;
    countdown_state_t w_state_nxt;
    logic             r_busy;
    logic             r_expired;
    logic             w_expired_nxt;
    logic             w_dec;
    logic             w_term;
    logic             w_term_hit;
    logic [WIDTH-1:0] w_count;

    // Decrement only in RUN and never alongside a load.
    assign w_dec      = (r_state == RUN) && i_wen && !i_load;
    assign w_term_hit = w_dec && w_term;

    countdown_64_bit_dp #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (i_load),
        .i_din    (i_din),
        .i_dec    (w_dec),
        .o_count  (w_count),
        .o_term_c (w_term)
    );

    // Next-state and expiry flag.
    always_comb begin
        w_state_nxt = r_state;
`ifdef COUNTDOWN_64_BIT_AUTO_RELOAD_EN
        w_expired_nxt = 1'b0;
`else
        w_expired_nxt = r_expired;
`endif
        if (i_load) begin
            w_expired_nxt = 1'b0;
            w_state_nxt   = (i_din != '0) ? RUN : IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt = IDLE;
                end
                RUN: begin
                    if (w_term_hit) begin
                        w_expired_nxt = 1'b1;
`ifndef COUNTDOWN_64_BIT_AUTO_RELOAD_EN
                        w_state_nxt   = DONE;
`endif
                    end
                end
                DONE: begin
                    if (i_ack) begin
                        w_state_nxt   = IDLE;
                        w_expired_nxt = 1'b0;
                    end
                end
                default: begin
                    w_state_nxt   = IDLE;
                    w_expired_nxt = 1'b0;
                end
            endcase
        end
    end

    // State, busy and expiry registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_busy    <= 1'b0;
            r_expired <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_busy    <= (w_state_nxt == RUN);
            r_expired <= w_expired_nxt;
        end
    end

    assign o_count   = w_count;
    assign o_busy    = r_busy;
    assign o_expired = r_expired;
    assign o_zero    = (w_count == '0);

endmodule

// File: tb/tb_countdown_64_bit.sv
module tb_countdown_64_bit;

    localparam int unsigned W = 64;

    logic         clk;
    logic         rst_n;
    logic         load;
    logic [W-1:0] din;
    logic         wen;
    logic         ack;
    logic [W-1:0] count;
    logic         busy;
    logic         expired;
    logic         zero;

    int n_checks;
    int n_pass;

    typedef struct {
        logic         ld;
        logic [W-1:0] d;
        logic         w;
        logic         a;
        logic [W-1:0] c;
        logic         b;
        logic         e;
    } vec_t;

    vec_t vecs[$];

    countdown_64_bit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (load),
        .i_din     (din),
        .i_wen     (wen),
        .i_ack     (ack),
        .o_count   (count),
        .o_busy    (busy),
        .o_expired (expired),
        .o_zero    (zero)
    );

    countdown_64_bit_formal #(.WIDTH(W)) u_chk (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (load),
        .i_din     (din),
        .i_wen     (wen),
        .i_ack     (ack),
        .i_count   (count),
        .i_busy    (busy),
        .i_expired (expired),
        .i_zero    (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Compare all four outputs at once: {count, busy, expired, zero}.
    task automatic check_out(input string name, input logic [W-1:0] c, input logic b, input logic e);
        check(name, 72'({count, busy, expired, zero}), 72'({c, b, e, (c == '0)}));
    endtask

    task automatic add(input logic ld, input logic [W-1:0] d, input logic w, input logic a,
                       input logic [W-1:0] c, input logic b, input logic e);
        vecs.push_back('{ld, d, w, a, c, b, e});
    endtask

    task automatic drive(input logic ld, input logic [W-1:0] d, input logic w, input logic a);
        load = ld;
        din  = d;
        wen  = w;
        ack  = a;
    endtask

    initial begin
        int  n;
        bit  got;
        n_checks = 0;
        n_pass   = 0;
        drive(1'b0, '0, 1'b0, 1'b0);
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #20;
        check_out("reset_values", '0, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        check_out("post_reset_idle", '0, 1'b0, 1'b0);

        //  ld   din                      wen   ack   count                    busy  exp
`ifdef COUNTDOWN_64_BIT_AUTO_RELOAD_EN
        add(1'b1, 64'd2,                  1'b1, 1'b0, 64'd2,                   1'b1, 1'b0);
        add(1'b0, 64'd0,                  1'b1, 1'b0, 64'd1,                   1'b1, 1'b0);
        add(1'b0, 64'd0,                  1'b1, 1'b0, 64'd2,                   1'b1, 1'b1);
        add(1'b0, 64'd0,                  1'b1, 1'b0, 64'd1,                   1'b1, 1'b0);
        add(1'b0, 64'd0,                  1'b1, 1'b0, 64'd2,                   1'b1, 1'b1);
        add(1'b0, 64'd0,                  1'b1, 1'b0, 64'd1,                   1'b1, 1'b0);
        add(1'b0, 64'd0,                  1'b1, 1'b0, 64'd2,                   1'b1, 1'b1);
        add(1'b0, 64'd0,                  1'b0, 1'b0, 64'd2,                   1'b1, 1'b0);
        add(1'b0, 64'd0,                  1'b0, 1'b1, 64'd2,                   1'b1, 1'b0);
        add(1'b1, 64'd0,                  1'b0, 1'b0, 64'd0,                   1'b0, 1'b0);
        add(1'b0, 64'd0,                  1'b1, 1'b0, 64'd0,                   1'b0, 1'b0);
        add(1'b1, 64'd7,                  1'b1, 1'b0, 64'd7,                   1'b1, 1'b0);
        add(1'b1, 64'hDEADBEEFCAFEBABE,   1'b1, 1'b1, 64'hDEADBEEFCAFEBABE,    1'b1, 1'b0);
`else
        add(1'b1, 64'd3,                  1'b1, 1'b0, 64'd3,                   1'b1, 1'b0);
        add(1'b0, 64'd0,                  1'b1, 1'b0, 64'd2,                   1'b1, 1'b0);
        add(1'b0, 64'd0,                  1'b1, 1'b0, 64'd1,                   1'b1, 1'b0);
        add(1'b0, 64'd0,                  1'b1, 1'b0, 64'd0,                   1'b0, 1'b1);
        add(1'b0, 64'd0,                  1'b0, 1'b0, 64'd0,                   1'b0, 1'b1);
        add(1'b0, 64'd0,                  1'b1, 1'b0, 64'd0,                   1'b0, 1'b1);
        add(1'b0, 64'd0,                  1'b0, 1'b0, 64'd0,                   1'b0, 1'b1);
        add(1'b0, 64'd0,                  1'b0, 1'b0, 64'd0,                   1'b0, 1'b1);
        add(1'b0, 64'd0,                  1'b0, 1'b0, 64'd0,                   1'b0, 1'b1);
        add(1'b0, 64'd0,                  1'b0, 1'b1, 64'd0,                   1'b0, 1'b0);
        add(1'b1, 64'd5,                  1'b0, 1'b0, 64'd5,                   1'b1, 1'b0);
        add(1'b0, 64'd0,                  1'b1, 1'b0, 64'd4,                   1'b1, 1'b0);
        add(1'b0, 64'd0,                  1'b0, 1'b0, 64'd4,                   1'b1, 1'b0);
        add(1'b0, 64'd0,                  1'b1, 1'b0, 64'd3,                   1'b1, 1'b0);
        add(1'b0, 64'd0,                  1'b0, 1'b0, 64'd3,                   1'b1, 1'b0);
        add(1'b0, 64'd0,                  1'b1, 1'b0, 64'd2,                   1'b1, 1'b0);
        add(1'b1, 64'd0,                  1'b0, 1'b0, 64'd0,                   1'b0, 1'b0);
        add(1'b0, 64'd0,                  1'b1, 1'b0, 64'd0,                   1'b0, 1'b0);
        add(1'b0, 64'd0,                  1'b0, 1'b1, 64'd0,                   1'b0, 1'b0);
        add(1'b0, 64'd0,                  1'b1, 1'b0, 64'd0,                   1'b0, 1'b0);
        add(1'b1, 64'd2,                  1'b1, 1'b0, 64'd2,                   1'b1, 1'b0);
        add(1'b0, 64'd0,                  1'b1, 1'b0, 64'd1,                   1'b1, 1'b0);
        add(1'b0, 64'd0,                  1'b1, 1'b0, 64'd0,                   1'b0, 1'b1);
        add(1'b1, 64'hDEADBEEFCAFEBABE,   1'b1, 1'b1, 64'hDEADBEEFCAFEBABE,    1'b1, 1'b0);
        add(1'b0, 64'd0,                  1'b1, 1'b0, 64'hDEADBEEFCAFEBABD,    1'b1, 1'b0);
        add(1'b1, 64'd7,                  1'b1, 1'b0, 64'd7,                   1'b1, 1'b0);
        add(1'b0, 64'd0,                  1'b1, 1'b0, 64'd6,                   1'b1, 1'b0);
        add(1'b0, 64'd0,                  1'b0, 1'b1, 64'd6,                   1'b1, 1'b0);
`endif

        foreach (vecs[i]) begin
            drive(vecs[i].ld, vecs[i].d, vecs[i].w, vecs[i].a);
            tick();
            check_out($sformatf("vec%0d", i), vecs[i].c, vecs[i].b, vecs[i].e);
        end

        // Expiry latency from a load of 20 with wen held high, bounded wait.
        drive(1'b1, 64'd20, 1'b1, 1'b0);
        tick();
        drive(1'b0, '0, 1'b1, 1'b0);
        n   = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            tick();
            n++;
            if (expired === 1'b1) got = 1'b1;
        end
        check("expiry_seen", 72'(got), 72'(1));
        check("expiry_latency", 72'(n), 72'(20));
`ifdef COUNTDOWN_64_BIT_AUTO_RELOAD_EN
        check_out("expiry_reloaded", 64'd20, 1'b1, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b0);
        tick();
        check_out("expiry_pulse_end", 64'd20, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b1);
        tick();
        check_out("ack_ignored_run", 64'd20, 1'b1, 1'b0);
`else
        check_out("expiry_done", 64'd0, 1'b0, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b0);
        tick();
        check_out("expiry_held", 64'd0, 1'b0, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b1);
        tick();
        check_out("ack_clears", 64'd0, 1'b0, 1'b0);
`endif

        // Asynchronous reset in the middle of RUN.
        drive(1'b1, 64'h10, 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, 1'b0, 1'b0);
        check_out("pre_reset_run", 64'h10, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_out("async_reset", '0, 1'b0, 1'b0);
        #2 rst_n = 1'b1;
        drive(1'b0, '0, 1'b1, 1'b0);
        tick();
        check_out("after_reset_wen", '0, 1'b0, 1'b0);
        drive(1'b1, 64'd1, 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, 1'b0, 1'b0);
        check_out("after_reset_load", 64'd1, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
